mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port instruction/data memory between the instruction-fetch requester (address from pc_reg) and the load/store (MEM-stage) requester.
- Sequences each access with a small FSM and a req/ack handshake to memory.
- Returns read data and a one-cycle done pulse to the requester, and drives per-requester stall outputs to the pipeline/PC logic.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte selects are DATA_W/8 bits)
- STARVE_MAX, 4, consecutive LS grants allowed while IF waits before IF is forced; valid range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk)
- if_req  in  1  fetch request; held until if_done or flush
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  discard any pending/in-flight fetch (branch redirect)
- if_rdata  out  DATA_W  fetched word, valid with if_done
- if_done  out  1  one-cycle fetch-complete pulse
- if_stall  out  1  if_req & ~if_done
- ls_req  in  1  load/store request; held until ls_done
- ls_we  in  1  1 = store
- ls_sel  in  DATA_W/8  byte enables
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_rdata  out  DATA_W  load data, valid with ls_done
- ls_done  out  1  one-cycle access-complete pulse
- ls_stall  out  1  ls_req & ~ls_done
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable
- mem_sel  out  DATA_W/8  byte enables (all ones for fetch)
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion from memory

Behaviour:
- States: IDLE, IF_ACC, LS_ACC, RESP. All outputs except the stalls are registered.
- Reset (rst==0): state=IDLE. mem_req, mem_we, if_done, ls_done, flush_pend=0. mem_sel, mem_addr, mem_wdata, if_rdata, ls_rdata=0. streak=0.
- IDLE arbitration, evaluated at the clock edge:
  - ls_req & ~(if_req & streak==STARVE_MAX): go LS_ACC; latch ls_* onto mem_*; mem_req<=1.
  - else if if_req & ~if_flush: go IF_ACC; mem_we=0; mem_sel=all ones; mem_addr=if_addr.
  - else stay IDLE.
- streak:
  - increments on an LS grant while if_req=1, saturating at STARVE_MAX.
  - clears on an IF grant, and on any IDLE cycle with if_req=0.
- IF_ACC/LS_ACC:
  - mem_* held stable until mem_ack=1.
  - On mem_ack: mem_req<=0, capture mem_rdata into the matching *_rdata, pulse the matching *_done, go RESP.
  - Fetch exception: if if_flush was seen at any cycle during IF_ACC (flush_pend) or on the ack cycle, suppress if_done; if_rdata is unchanged.
  - The memory access is never aborted.
- RESP: one cycle. No arbitration; the done pulse is visible here; clear flush_pend; go IDLE. The requester must drop or change its req by the next edge.
- Latency: with a zero-wait memory (ack in the first mem_req cycle), req at cycle 0 gives mem_req at cycle 1 and done at cycle 2. Next grant is at cycle 3. Throughput is 1 access / 3 cycles.
- Stores: ls_rdata unchanged; ls_done still pulses.
- if_flush while in IDLE blocks the IF grant that cycle only.
- Simultaneous if_req and ls_req: LS wins unless streak==STARVE_MAX.
- mem_ack while in IDLE or RESP is ignored.
- rst deasserted mid-access: immediately IDLE, mem_req=0, no done. The memory model is reset alongside.
- Both done outputs are never high in the same cycle.

Decomposition:
- Shared header holds the FSM state encodings (2 bits) and the ArbIdle/ArbIf/ArbLs/ArbResp constants, alongside the existing Defines.vh widths (InstAddrBus, ZeroWord).
- No sub-module; the starvation counter is inline.

Test Plan:
- Single fetch, zero-wait memory: if_req=1, if_addr=0x10, mem_rdata=0xDEADBEEF -> mem_req in cycle 1 with mem_addr=0x10, mem_sel=4'hF; if_done and if_rdata=0xDEADBEEF in cycle 2; if_stall high in cycles 0-1.
- Store with 2 wait states: ls_we=1, ls_addr=0x200, ls_sel=4'b0011, ls_wdata=0x1234 -> mem_* stable for 3 cycles until ack; ls_done one cycle after ack; ls_rdata unchanged.
- Simultaneous requests: if_req and ls_req both high -> LS served first. IF is granted in the IDLE cycle following LS's RESP.
- Starvation, STARVE_MAX=4: ls_req held high with new accesses every round, if_req high -> exactly 4 LS grants, then 1 IF grant, then LS resumes.
- Flush mid-fetch: if_flush pulsed in the 2nd cycle of a 3-wait fetch -> mem_req stays high until ack; no if_done; if_rdata unchanged; arbiter returns to IDLE.
- Reset mid-access: rst=0 during LS_ACC -> next cycle mem_req=0, state IDLE, no ls_done. After release, a new fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter.
//   AddrW / DataW / SelW : default bus widths (byte selects = DataW/8)
//   InstAddrBus, ZeroWord: widths/constants shared with the rest of the core
//   ArbIdle..ArbResp     : 2-bit FSM state encodings for the arbiter
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int AddrW       = 32;
  localparam int DataW       = 32;
  localparam int SelW        = DataW / 8;
  localparam int InstAddrBus = AddrW;

  localparam logic [DataW-1:0] ZeroWord = '0;

  localparam int StateW = 2;
  localparam logic [StateW-1:0] ArbIdle = 2'd0;
  localparam logic [StateW-1:0] ArbIf   = 2'd1;
  localparam logic [StateW-1:0] ArbLs   = 2'd2;
  localparam logic [StateW-1:0] ArbResp = 2'd3;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses around the memory arbiter:
//   if_*  : instruction-fetch requester (address from the PC)
//   ls_*  : load/store requester (MEM stage)
//   mem_* : single-port memory with a req/ack handshake
// Modports:
//   master : the arbiter (drives mem_*, done/rdata/stall back to requesters)
//   slave  : the environment (pipeline requesters and the memory)
// ---------------------------------------------------------------------------
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = AddrW,
  parameter int DATA_W = DataW
);

  localparam int SEL_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  logic              ls_req;
  logic              ls_we;
  logic [SEL_W-1:0]  ls_sel;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_done;
  logic              ls_stall;

  logic              mem_req;
  logic              mem_we;
  logic [SEL_W-1:0]  mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_done, if_stall,
    input  ls_req, ls_we, ls_sel, ls_addr, ls_wdata,
    output ls_rdata, ls_done, ls_stall,
    output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_done, if_stall,
    output ls_req, ls_we, ls_sel, ls_addr, ls_wdata,
    input  ls_rdata, ls_done, ls_stall,
    input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between instruction fetch and load/store.
// Each access runs IDLE -> IF_ACC/LS_ACC -> RESP -> IDLE; the done pulse and
// read data are visible in RESP. Load/store has priority, but after
// STARVE_MAX consecutive LS grants with a fetch waiting, the fetch is forced.
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous reset, active low
//   bus    : mem_arbiter_if.master (requester buses and memory bus)
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = AddrW,
  parameter int DATA_W     = DataW,
  parameter int STARVE_MAX = 4
)(
  input  logic          i_clk,
  input  logic          i_rst,
  mem_arbiter_if.master bus
);

  localparam int SEL_W = DATA_W / 8;
  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic [StateW-1:0] r_state;
  logic              r_flushPend;
  logic [3:0]        r_streak;
  logic              r_memReq;
  logic              r_memWe;
  logic [SEL_W-1:0]  r_memSel;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_lsRdata;
  logic              r_ifDone;
  logic              r_lsDone;

  logic w_starved;
  logic w_lsWins;

  // A waiting fetch that has watched STARVE_MAX LS grants in a row wins.
  assign w_starved = bus.if_req && (r_streak == StarveMax);
  assign w_lsWins  = bus.ls_req && !w_starved;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= ArbIdle;
      r_flushPend <= 1'b0;
      r_streak    <= '0;
      r_memReq    <= 1'b0;
      r_memWe     <= 1'b0;
      r_memSel    <= '0;
      r_memAddr   <= '0;
      r_memWdata  <= '0;
      r_ifRdata   <= '0;
      r_lsRdata   <= '0;
      r_ifDone    <= 1'b0;
      r_lsDone    <= 1'b0;
    end else begin
      // Done strobes are single-cycle; they are only set on an ack edge.
      r_ifDone <= 1'b0;
      r_lsDone <= 1'b0;
      case (r_state)
        ArbIdle: begin
          if (w_lsWins) begin
            r_state    <= ArbLs;
            r_memReq   <= 1'b1;
            r_memWe    <= bus.ls_we;
            r_memSel   <= bus.ls_sel;
            r_memAddr  <= bus.ls_addr;
            r_memWdata <= bus.ls_wdata;
            if (!bus.if_req)
              r_streak <= '0;
            else if (r_streak != StarveMax)
              r_streak <= r_streak + 4'd1;
          end else if (bus.if_req && !bus.if_flush) begin
            r_state   <= ArbIf;
            r_memReq  <= 1'b1;
            r_memWe   <= 1'b0;
            r_memSel  <= '1;
            r_memAddr <= bus.if_addr;
            r_streak  <= '0;
          end else if (!bus.if_req) begin
            r_streak <= '0;
          end
        end
        ArbIf: begin
          // A redirect during the fetch poisons the result, but the memory
          // access itself still runs to its ack.
          if (bus.if_flush)
            r_flushPend <= 1'b1;
          if (bus.mem_ack) begin
            r_memReq <= 1'b0;
            r_state  <= ArbResp;
            if (!(r_flushPend || bus.if_flush)) begin
              r_ifRdata <= bus.mem_rdata;
              r_ifDone  <= 1'b1;
            end
          end
        end
        ArbLs: begin
          if (bus.mem_ack) begin
            r_memReq <= 1'b0;
            r_state  <= ArbResp;
            r_lsDone <= 1'b1;
            if (!r_memWe)
              r_lsRdata <= bus.mem_rdata;
          end
        end
        default: begin
          // RESP: gives the requester one cycle to retire its request.
          r_flushPend <= 1'b0;
          r_state     <= ArbIdle;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_memReq;
  assign bus.mem_we    = r_memWe;
  assign bus.mem_sel   = r_memSel;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.if_rdata  = r_ifRdata;
  assign bus.if_done   = r_ifDone;
  assign bus.ls_rdata  = r_lsRdata;
  assign bus.ls_done   = r_lsDone;

  // Stalls are combinational so the pipeline releases in the done cycle.
  assign bus.if_stall = bus.if_req && !r_ifDone;
  assign bus.ls_stall = bus.ls_req && !r_lsDone;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter (STARVE_MAX = 4): a table of single
// transactions followed by hand-written multi-cycle sequences (simultaneous
// requests, starvation, fetch flush, reset mid-access). A small memory model
// acks after a programmable number of wait states.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    logic        isLs;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waitN;
    logic [31:0] memData;
    logic [3:0]  expSel;
    logic [31:0] expRdata;
  } vec_t;

  logic clk;
  logic rst;
  int compareCount;
  int mismatchCount;
  int memWait;
  logic [31:0] memData;
  int waitCnt;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: acks after memWait cycles of mem_req, resets with the DUT.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'hBAD0BAD0;
      waitCnt       = 0;
    end else if (bus.mem_req) begin
      if (waitCnt == memWait) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = memData;
        waitCnt       = 0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hBAD0BAD0;
        waitCnt       = waitCnt + 1;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'hBAD0BAD0;
      waitCnt       = 0;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #300000;
    mismatchCount = mismatchCount + 1;
    $display("[TB] FAIL watchdog: actual still running, required finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compareCount = compareCount + 1;
    if (act !== exp) begin
      mismatchCount = mismatchCount + 1;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // Runs one complete transaction starting in an IDLE cycle.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    logic done;
    @(negedge clk);
    memWait = v.waitN;
    memData = v.memData;
    if (v.isLs) begin
      bus.ls_req   = 1'b1;
      bus.ls_we    = v.we;
      bus.ls_sel   = v.sel;
      bus.ls_addr  = v.addr;
      bus.ls_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    #1;
    checkOutput("stallCycle0", v.isLs ? bus.ls_stall : bus.if_stall, 1);
    @(negedge clk);
    checkOutput("grantMemReq", bus.mem_req, 1);
    checkOutput("grantMemAddr", bus.mem_addr, v.addr);
    checkOutput("grantMemSel", bus.mem_sel, v.expSel);
    checkOutput("grantMemWe", bus.mem_we, v.isLs ? v.we : 1'b0);
    checkOutput("stallCycle1", v.isLs ? bus.ls_stall : bus.if_stall, 1);
    if (v.isLs && v.we)
      checkOutput("grantMemWdata", bus.mem_wdata, v.wdata);
    done = 1'b0;
    cyc  = 1;
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc = cyc + 1;
      if (bus.if_done || bus.ls_done)
        done = 1'b1;
      else begin
        checkOutput("waitMemReqHeld", bus.mem_req, 1);
        checkOutput("waitMemAddrHeld", bus.mem_addr, v.addr);
      end
    end
    checkOutput("doneSeen", done, 1);
    checkOutput("doneCycle", cyc, v.waitN + 2);
    checkOutput("ifDone", bus.if_done, !v.isLs);
    checkOutput("lsDone", bus.ls_done, v.isLs);
    checkOutput("rdata", v.isLs ? bus.ls_rdata : bus.if_rdata, v.expRdata);
    checkOutput("stallAtDone", v.isLs ? bus.ls_stall : bus.if_stall, 0);
    checkOutput("memReqAtDone", bus.mem_req, 0);
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
  endtask

  vec_t vecs [0:5];
  vec_t postReset;

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    memWait       = 0;
    memData       = '0;
    waitCnt       = 0;
    rst           = 1'b0;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_flush  = 1'b0;
    bus.ls_req    = 1'b0;
    bus.ls_we     = 1'b0;
    bus.ls_sel    = '0;
    bus.ls_addr   = '0;
    bus.ls_wdata  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    //              isLs  we    sel    addr          wdata         wait memData       expSel expRdata
    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h00000010, 32'h0,        0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h00000200, 32'h00001234, 2, 32'h55555555, 4'h3, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h00000204, 32'h0,        1, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b1, 4'h8, 32'h00000208, 32'hAABBCCDD, 0, 32'h11111111, 4'h8, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 4'hF, 32'h00000014, 32'h0,        3, 32'h01234567, 4'hF, 32'h01234567};
    vecs[5] = '{1'b1, 1'b0, 4'h1, 32'hFFFFFFFC, 32'h0,        0, 32'h000000A5, 4'h1, 32'h000000A5};
    postReset = '{1'b0, 1'b0, 4'hF, 32'h00000600, 32'h0, 1, 32'h31415926, 4'hF, 32'h31415926};

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rstMemReq", bus.mem_req, 0);
    checkOutput("rstMemWe", bus.mem_we, 0);
    checkOutput("rstMemSel", bus.mem_sel, 0);
    checkOutput("rstMemAddr", bus.mem_addr, 0);
    checkOutput("rstMemWdata", bus.mem_wdata, 0);
    checkOutput("rstIfDone", bus.if_done, 0);
    checkOutput("rstLsDone", bus.ls_done, 0);
    checkOutput("rstIfRdata", bus.if_rdata, 0);
    checkOutput("rstLsRdata", bus.ls_rdata, 0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i]);

    // Simultaneous requests: LS first, IF in the IDLE after LS's RESP.
    @(negedge clk);
    memWait = 0;
    memData = 32'h00000077;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_sel  = 4'hF;
    bus.ls_addr = 32'h300;
    @(negedge clk);
    checkOutput("simLsGrantAddr", bus.mem_addr, 32'h300);
    @(negedge clk);
    checkOutput("simLsDone", bus.ls_done, 1);
    checkOutput("simIfNotDone", bus.if_done, 0);
    checkOutput("simLsRdata", bus.ls_rdata, 32'h77);
    checkOutput("simIfStall", bus.if_stall, 1);
    bus.ls_req = 1'b0;
    memData = 32'h00000088;
    @(negedge clk);
    checkOutput("simIdleMemReq", bus.mem_req, 0);
    @(negedge clk);
    checkOutput("simIfGrantReq", bus.mem_req, 1);
    checkOutput("simIfGrantAddr", bus.mem_addr, 32'h40);
    @(negedge clk);
    checkOutput("simIfDone", bus.if_done, 1);
    checkOutput("simIfRdata", bus.if_rdata, 32'h88);
    checkOutput("simLsNotDone", bus.ls_done, 0);
    bus.if_req = 1'b0;

    // Starvation: both held; expect LS x4, then IF, then LS again.
    @(negedge clk);
    memWait = 0;
    memData = 32'h50000000;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_sel  = 4'hF;
    bus.ls_addr = 32'h400;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      checkOutput($sformatf("starveGrantIsIf%0d", r), bus.mem_addr < 32'h400, r == 4);
      @(negedge clk);
      checkOutput($sformatf("starveIfDone%0d", r), bus.if_done, r == 4);
      if (bus.ls_done) bus.ls_addr = bus.ls_addr + 32'd4;
      if (bus.if_done) bus.if_addr = bus.if_addr + 32'd4;
      if (r == 5) begin
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
      end
      @(negedge clk);
    end

    // Flush in the 2nd cycle of a 3-wait fetch.
    memWait = 3;
    memData = 32'h99999999;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h90;
    @(negedge clk);
    checkOutput("flushGrantAddr", bus.mem_addr, 32'h90);
    @(negedge clk);
    bus.if_flush = 1'b1;
    bus.if_req   = 1'b0;
    @(negedge clk);
    checkOutput("flushMemReqHeld", bus.mem_req, 1);
    bus.if_flush = 1'b0;
    @(negedge clk);
    checkOutput("flushAckCycleReq", bus.mem_req, 1);
    @(negedge clk);
    checkOutput("flushNoDone", bus.if_done, 0);
    checkOutput("flushRdataKept", bus.if_rdata, 32'h50000000);
    checkOutput("flushMemReqDrop", bus.mem_req, 0);
    @(negedge clk);
    checkOutput("flushIdleReq", bus.mem_req, 0);
    // Flush while IDLE blocks only that cycle's grant.
    memWait = 0;
    memData = 32'hABCD0123;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h94;
    bus.if_flush = 1'b1;
    @(negedge clk);
    checkOutput("idleFlushBlocked", bus.mem_req, 0);
    bus.if_flush = 1'b0;
    @(negedge clk);
    checkOutput("idleFlushLaterGrant", bus.mem_req, 1);
    checkOutput("idleFlushLaterAddr", bus.mem_addr, 32'h94);
    @(negedge clk);
    checkOutput("postFlushIfDone", bus.if_done, 1);
    checkOutput("postFlushIfRdata", bus.if_rdata, 32'hABCD0123);
    bus.if_req = 1'b0;

    // Reset during an LS access.
    @(negedge clk);
    memWait = 5;
    memData = 32'h0BADF00D;
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_sel   = 4'hF;
    bus.ls_addr  = 32'h500;
    bus.ls_wdata = 32'h0000FEED;
    @(negedge clk);
    checkOutput("rstMidGrant", bus.mem_req, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rstMidMemReq", bus.mem_req, 0);
    checkOutput("rstMidLsDone", bus.ls_done, 0);
    checkOutput("rstMidMemAddr", bus.mem_addr, 0);
    bus.ls_req = 1'b0;
    bus.ls_we  = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rstAfterNoDone%0d", k), bus.ls_done, 0);
      checkOutput($sformatf("rstAfterNoReq%0d", k), bus.mem_req, 0);
    end
    checkOutput("rstAfterLsRdata", bus.ls_rdata, 0);
    applyStimulus(postReset);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
